// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the issue-stage hazard/forwarding controller: forwarding-select
// encoding, architectural register constants and the in-flight slot record.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_ALU  = 2'b01,
        FWD_LDR  = 2'b10,
        FWD_SPEC = 2'b11
    } fwd_sel_e;

    localparam logic [3:0] REG_PC = 4'd15;
    localparam logic [3:0] REG_LR = 4'd14;

    typedef struct packed {
        logic       v;
        logic [3:0] dest;
    } slot_t;

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-to-controller bundle: instruction descriptor in, handshake, forwarding
// selects, operand enables and status out.
interface hazard_fwd_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic             d_valid;
    logic             d_ready;
    logic [3:0]       d_rn;
    logic [3:0]       d_rm;
    logic [3:0]       d_rs;
    logic             d_use_rn;
    logic             d_use_rm;
    logic             d_use_rs;
    logic             d_alu_wr;
    logic [3:0]       d_alu_dest;
    logic             d_is_ldr;
    logic [3:0]       d_ldr_dest;
    logic             flush;
    fwd_sel_e         sel_A_in;
    fwd_sel_e         sel_B_in;
    fwd_sel_e         sel_shift_in;
    logic             en_A;
    logic             en_B;
    logic             en_S;
    logic             e_valid;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_valid, d_rn, d_rm, d_rs, d_use_rn, d_use_rm, d_use_rs,
               d_alu_wr, d_alu_dest, d_is_ldr, d_ldr_dest, flush,
        input  d_ready, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S,
               e_valid, stall_cnt
    );

    modport slave (
        input  d_valid, d_rn, d_rm, d_rs, d_use_rn, d_use_rm, d_use_rs,
               d_alu_wr, d_alu_dest, d_is_ldr, d_ldr_dest, flush,
        output d_ready, sel_A_in, sel_B_in, sel_shift_in, en_A, en_B, en_S,
               e_valid, stall_cnt
    );

endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel_lookup.sv
// Forwarding select and load-use hit for one source operand, given the execute
// slot and the load-return pipeline.
module fwd_sel_lookup
    import pipe_ctrl_pkg::*;
#(
    parameter int LDR_LAT  = 2,
    parameter bit IS_A     = 1'b0,
    parameter bit IS_SHIFT = 1'b0
) (
    input  logic                 use_op,
    input  logic [3:0]           r,
    input  logic                 e_valid,
    input  logic                 e_wr,
    input  logic [3:0]           e_dest,
    input  slot_t [LDR_LAT:1]    ld,
    output fwd_sel_e             sel,
    output logic                 hit
);

    logic pc_exempt;

    // The A operand reads the PC through its own path, so r15 never forwards or stalls there.
    assign pc_exempt = IS_A && (r == REG_PC);

    always_comb begin
        sel = FWD_RF;
        if (!use_op) begin
            sel = IS_SHIFT ? FWD_SPEC : FWD_RF;
        end else if (pc_exempt) begin
            sel = FWD_SPEC;
        end else if (e_valid && e_wr && (e_dest == r)) begin
            sel = FWD_ALU;
        end else if (ld[LDR_LAT].v && (ld[LDR_LAT].dest == r)) begin
            sel = FWD_LDR;
        end
    end

    // Loads still short of the return slot cannot be forwarded yet.
    always_comb begin
        hit = 1'b0;
        for (int k = 1; k < LDR_LAT; k++) begin
            if (ld[k].v && (ld[k].dest == r)) begin
                hit = 1'b1;
            end
        end
        if (!use_op || pc_exempt) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Issue-stage controller: tracks in-flight ALU and load destinations, drives operand
// forwarding selects and enables, stalls on load-use and squashes on flush.
module hazard_fwd_ctrl #(
    parameter int LDR_LAT = 2,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_ctrl_if.slave bus
);

    import pipe_ctrl_pkg::*;

    logic                      e_valid_q;
    logic                      e_wr_q;
    logic [3:0]                e_dest_q;
    logic [LDR_LAT:1]          ld_v_q;
    logic [LDR_LAT:1][3:0]     ld_dest_q;
    logic [CNT_W-1:0]          stall_cnt_q;
    slot_t [LDR_LAT:1]         ld_view;

    fwd_sel_e                  sel_a;
    fwd_sel_e                  sel_b;
    fwd_sel_e                  sel_s;
    logic                      hit_a;
    logic                      hit_b;
    logic                      hit_s;
    logic                      stall;
    logic                      issue;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        ld_view = '0;
        for (int k = 1; k <= LDR_LAT; k++) begin
            ld_view[k].v    = ld_v_q[k];
            ld_view[k].dest = ld_dest_q[k];
        end
    end

    fwd_sel_lookup #(.LDR_LAT(LDR_LAT), .IS_A(1'b1), .IS_SHIFT(1'b0)) u_look_a (
        .use_op (bus.d_use_rn),
        .r      (bus.d_rn),
        .e_valid(e_valid_q),
        .e_wr   (e_wr_q),
        .e_dest (e_dest_q),
        .ld     (ld_view),
        .sel    (sel_a),
        .hit    (hit_a)
    );

    fwd_sel_lookup #(.LDR_LAT(LDR_LAT), .IS_A(1'b0), .IS_SHIFT(1'b0)) u_look_b (
        .use_op (bus.d_use_rm),
        .r      (bus.d_rm),
        .e_valid(e_valid_q),
        .e_wr   (e_wr_q),
        .e_dest (e_dest_q),
        .ld     (ld_view),
        .sel    (sel_b),
        .hit    (hit_b)
    );

    fwd_sel_lookup #(.LDR_LAT(LDR_LAT), .IS_A(1'b0), .IS_SHIFT(1'b1)) u_look_s (
        .use_op (bus.d_use_rs),
        .r      (bus.d_rs),
        .e_valid(e_valid_q),
        .e_wr   (e_wr_q),
        .e_dest (e_dest_q),
        .ld     (ld_view),
        .sel    (sel_s),
        .hit    (hit_s)
    );

    // Flush overrides a stall: the instruction is dropped, not held.
    assign stall = bus.d_valid & ~bus.flush & (hit_a | hit_b | hit_s);
    assign issue = bus.d_valid & ~stall & ~bus.flush;

    assign bus.d_ready      = ~stall;
    assign bus.en_A         = issue;
    assign bus.en_B         = issue;
    assign bus.en_S         = issue;
    assign bus.sel_A_in     = sel_a;
    assign bus.sel_B_in     = sel_b;
    assign bus.sel_shift_in = sel_s;
    assign bus.e_valid      = e_valid_q;
    assign bus.stall_cnt    = stall_cnt_q;

    // Issue -> execute / load-return boundary: valids and counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q   <= 1'b0;
            ld_v_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_valid_q <= issue;
            ld_v_q[1] <= issue & bus.d_is_ldr;
            for (int k = 2; k <= LDR_LAT; k++) begin
                ld_v_q[k] <= ld_v_q[k-1];
            end
            if (stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    // Issue -> execute / load-return boundary: destination payload, qualified by the valids
    always_ff @(posedge clk) begin
        e_wr_q       <= bus.d_alu_wr;
        e_dest_q     <= bus.d_alu_dest;
        ld_dest_q[1] <= bus.d_ldr_dest;
        for (int k = 2; k <= LDR_LAT; k++) begin
            ld_dest_q[k] <= ld_dest_q[k-1];
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: a cycle-log reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_hazard_fwd_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int LAT  = 2;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hazard_fwd_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_fwd_ctrl #(.LDR_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a log of what issued on each cycle, indexed by absolute cycle number.
    bit       lg_iss [0:4095];
    bit       lg_wr  [0:4095];
    bit       lg_ld  [0:4095];
    int       lg_ad  [0:4095];
    int       lg_ldd [0:4095];
    int       cyc     = 0;
    int       rst_cyc = -1;
    int       m_cnt   = 0;

    function automatic bit past_ok(input int k);
        return (cyc - k >= 0) && (cyc - k > rst_cyc);
    endfunction

    function automatic int exp_sel(input int kind, input bit u, input int r,
                                   input bit ev, input bit ew, input int ed,
                                   input bit lv, input int ld);
        if (!u) return (kind == 2) ? 3 : 0;
        if (kind == 0 && r == 15) return 3;
        if (ev && ew && ed == r) return 1;
        if (lv && ld == r) return 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        bit ev, ew, lv, h, st, iss;
        int ed, ldd;
        if (rst) begin
            rst_cyc = cyc;
            m_cnt   = 0;
        end
        ev = 0; ew = 0; ed = 0; lv = 0; ldd = 0; h = 0;
        if (past_ok(1)) begin
            ev = lg_iss[cyc-1];
            ew = lg_wr[cyc-1];
            ed = lg_ad[cyc-1];
        end
        if (past_ok(LAT)) begin
            lv  = lg_iss[cyc-LAT] && lg_ld[cyc-LAT];
            ldd = lg_ldd[cyc-LAT];
        end
        for (int k = 1; k < LAT; k++) begin
            if (past_ok(k) && lg_iss[cyc-k] && lg_ld[cyc-k]) begin
                if (bus.d_use_rn && bus.d_rn != 4'd15 && int'(bus.d_rn) == lg_ldd[cyc-k]) h = 1;
                if (bus.d_use_rm && int'(bus.d_rm) == lg_ldd[cyc-k]) h = 1;
                if (bus.d_use_rs && int'(bus.d_rs) == lg_ldd[cyc-k]) h = 1;
            end
        end
        st  = bus.d_valid && !bus.flush && h;
        iss = bus.d_valid && !bus.flush && !st;

        chk("model_d_ready",   bus.d_ready,  st ? 0 : 1);
        chk("model_en_A",      bus.en_A,     iss);
        chk("model_en_B",      bus.en_B,     iss);
        chk("model_en_S",      bus.en_S,     iss);
        chk("model_e_valid",   bus.e_valid,  ev);
        chk("model_stall_cnt", bus.stall_cnt, m_cnt);
        chk("model_sel_A",     bus.sel_A_in,
            exp_sel(0, bus.d_use_rn, int'(bus.d_rn), ev, ew, ed, lv, ldd));
        chk("model_sel_B",     bus.sel_B_in,
            exp_sel(1, bus.d_use_rm, int'(bus.d_rm), ev, ew, ed, lv, ldd));
        chk("model_sel_shift", bus.sel_shift_in,
            exp_sel(2, bus.d_use_rs, int'(bus.d_rs), ev, ew, ed, lv, ldd));

        if (!rst) begin
            lg_iss[cyc] = iss;
            lg_wr[cyc]  = bus.d_alu_wr;
            lg_ad[cyc]  = int'(bus.d_alu_dest);
            lg_ld[cyc]  = bus.d_is_ldr;
            lg_ldd[cyc] = int'(bus.d_ldr_dest);
            if (st && m_cnt < CMAX) m_cnt++;
        end
        cyc++;
    end

    task automatic set_in(input bit v, input int rn, input bit urn, input int rm, input bit urm,
                          input int rs, input bit urs, input bit aw, input int ad,
                          input bit ld, input int ldd);
        bus.d_valid    = v;
        bus.d_rn       = rn[3:0];
        bus.d_use_rn   = urn;
        bus.d_rm       = rm[3:0];
        bus.d_use_rm   = urm;
        bus.d_rs       = rs[3:0];
        bus.d_use_rs   = urs;
        bus.d_alu_wr   = aw;
        bus.d_alu_dest = ad[3:0];
        bus.d_is_ldr   = ld;
        bus.d_ldr_dest = ldd[3:0];
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.flush = 1'b0;
        set_in(1, 2, 1, 3, 1, 0, 0, 1, 1, 0, 0);
        #3;
        chk("rst_e_valid",   bus.e_valid, 0);
        chk("rst_d_ready",   bus.d_ready, 1);
        chk("rst_en_A",      bus.en_A, 1);
        chk("rst_sel_A",     bus.sel_A_in, 0);
        chk("rst_sel_shift", bus.sel_shift_in, 3);
        chk("rst_stall_cnt", bus.stall_cnt, 0);
        next(); next();
        rst = 1'b0;
        idle();
        next();

        // ALU back-to-back: ADD r1,r2,r3 then ADD r2,r1,r3
        set_in(1, 2, 1, 3, 1, 0, 0, 1, 1, 0, 0); #1;
        chk("t1_first_sel_A", bus.sel_A_in, 0);
        next();
        set_in(1, 1, 1, 3, 1, 0, 0, 1, 2, 0, 0); #1;
        chk("t1_sel_A_alu",  bus.sel_A_in, 1);
        chk("t1_d_ready",    bus.d_ready, 1);
        chk("t1_e_valid",    bus.e_valid, 1);
        chk("t1_stall_cnt",  bus.stall_cnt, 0);
        next(); idle(); next(); next();

        // Load-use: LDR r3,[r4] then ADD r4,r3
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 3); next();
        set_in(1, 3, 1, 0, 0, 0, 0, 1, 4, 0, 0); #1;
        chk("t2_stall_ready", bus.d_ready, 0);
        chk("t2_stall_en_A",  bus.en_A, 0);
        chk("t2_stall_en_S",  bus.en_S, 0);
        next(); #1;
        chk("t2_sel_A_ldr",   bus.sel_A_in, 2);
        chk("t2_ready_after", bus.d_ready, 1);
        chk("t2_stall_cnt",   bus.stall_cnt, 1);
        chk("t2_e_bubble",    bus.e_valid, 0);
        next(); idle(); next(); next();

        // LDR r5, unrelated ADD r6, then MOV using r5 as shift amount
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 5); next();
        set_in(1, 7, 1, 0, 0, 0, 0, 1, 6, 0, 0); #1;
        chk("t3_no_stall", bus.d_ready, 1);
        next();
        set_in(1, 0, 0, 8, 1, 5, 1, 1, 9, 0, 0); #1;
        chk("t3_sel_shift_ldr", bus.sel_shift_in, 2);
        chk("t3_sel_A_unused",  bus.sel_A_in, 0);
        chk("t3_d_ready",       bus.d_ready, 1);
        next(); idle(); next(); next();

        // Flush during a load-use stall
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 3); next();
        set_in(1, 3, 1, 0, 0, 0, 0, 1, 4, 0, 0); #1;
        chk("t4_stall_ready", bus.d_ready, 0);
        bus.flush = 1'b1; #1;
        chk("t4_flush_ready", bus.d_ready, 1);
        chk("t4_flush_en_A",  bus.en_A, 0);
        next();
        bus.flush = 1'b0;
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t4_e_bubble",    bus.e_valid, 0);
        chk("t4_stall_cnt",   bus.stall_cnt, 1);
        chk("t4_load_kept",   bus.sel_A_in, 2);
        next(); idle(); next(); next();

        // r15 on A while E writes r15; B still forwards it, unused rs -> special
        set_in(1, 2, 1, 0, 0, 0, 0, 1, 15, 0, 0); next();
        set_in(1, 15, 1, 15, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("t5_sel_A_pc",    bus.sel_A_in, 3);
        chk("t5_sel_B_alu",   bus.sel_B_in, 1);
        chk("t5_sel_shift",   bus.sel_shift_in, 3);
        next(); idle(); next(); next();

        // Same register both in E (ALU) and returning from load: ALU wins
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 10); next();
        set_in(1, 0, 1, 0, 0, 0, 0, 1, 10, 0, 0); #1;
        chk("t6_no_stall", bus.d_ready, 1);
        next();
        set_in(1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0); #1;
        chk("t6_sel_B_alu_wins", bus.sel_B_in, 1);
        next(); idle(); next(); next();

        // Reset pulsed mid-stall with a load pending
        set_in(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 3); next();
        set_in(1, 3, 1, 0, 0, 0, 0, 1, 4, 0, 0); #1;
        chk("t7_stall_ready", bus.d_ready, 0);
        rst = 1'b1; #1;
        chk("t7_rst_ready",   bus.d_ready, 1);
        chk("t7_rst_e_valid", bus.e_valid, 0);
        chk("t7_rst_cnt",     bus.stall_cnt, 0);
        next();
        rst = 1'b0; #1;
        chk("t7_after_ready", bus.d_ready, 1);
        chk("t7_after_sel_A", bus.sel_A_in, 0);
        chk("t7_after_e_vld", bus.e_valid, 0);
        chk("t7_after_cnt",   bus.stall_cnt, 0);
        next(); idle(); next(); next();

        // Saturation: repeated LDR r3,[r3] alternates issue/stall
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 3);
        for (int i = 0; i < 40; i++) next();
        idle(); #1;
        chk("t8_saturated", bus.stall_cnt, CMAX);
        next(); next(); next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
